// File: rtl/text_pkg.sv
// Shared text definitions for the case converter and its downstream stages.
package text_pkg;

  localparam logic [7:0] CH_A_UP  = 8'h41;
  localparam logic [7:0] CH_Z_UP  = 8'h5A;
  localparam logic [7:0] CH_A_LO  = 8'h61;
  localparam logic [7:0] CH_Z_LO  = 8'h7A;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef struct packed {
    logic       cap;
    logic [7:0] ch;
  } entry_t;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= CH_A_UP) && (c <= CH_Z_UP)) || ((c >= CH_A_LO) && (c <= CH_Z_LO));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; ready depends only on occupancy.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic                        push, pop;

  assign in_ready  = (level != (AW+1)'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Gate the head so an empty FIFO presents zeros rather than stale storage.
  assign out_data  = out_valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/case_stream_collector.sv
// Buffers converter output bytes and keeps saturating char/capital/word statistics.
module case_stream_collector
  import text_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_char,
  input  logic                   in_cap,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_char,
  output logic                   out_cap,
  input  logic                   stats_clr,
  output logic [CNT_W-1:0]       char_count,
  output logic [CNT_W-1:0]       cap_count,
  output logic [CNT_W-1:0]       word_count,
  output logic [$clog2(DEPTH):0] level
);
  entry_t in_ent, out_ent;
  logic   push, letter, in_word;

  assign in_ent   = '{cap: in_cap, ch: in_char};
  assign out_char = out_ent.ch;
  assign out_cap  = out_ent.cap;
  assign push     = in_valid & in_ready;
  assign letter   = is_letter(in_char);

  sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_ent),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_ent),
    .level     (level)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // Clear wins over a coincident push: the byte is buffered but not counted.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      char_count <= '0;
      cap_count  <= '0;
      word_count <= '0;
      in_word    <= 1'b0;
    end else if (push) begin
      char_count <= sat_inc(char_count);
      if (in_cap)             cap_count  <= sat_inc(cap_count);
      if (letter && !in_word) word_count <= sat_inc(word_count);
      in_word <= letter;
    end
  end

endmodule

// File: doc/case_stream_collector.md
Name: case_stream_collector

Overview:
- Downstream stage of the case converter. Accepts the converter's byte (`out`) and capital flag (`cap`) as a valid/ready stream.
- Buffers accepted bytes in a small synchronous FIFO and re-emits them on a valid/ready output.
- Maintains running statistics: characters, capitals and words accepted.
- Sits between the converter and the UART/display sink. Absorbs back-pressure and gives software a cheap text summary.

Parameters:
- DEPTH, 8, FIFO entries (power of two, ≥2).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream byte available.
- in_ready  output  1  collector can accept a byte this cycle.
- in_char  input  8  converted ASCII byte (converter `out`).
- in_cap  input  1  converter `cap` flag for this byte.
- out_valid  output  1  head byte available.
- out_ready  input  1  downstream accepts head byte.
- out_char  output  8  head byte.
- out_cap  output  1  cap flag stored with head byte.
- stats_clr  input  1  synchronous clear of statistics.
- char_count  output  CNT_W  accepted bytes.
- cap_count  output  CNT_W  accepted bytes with in_cap=1.
- word_count  output  CNT_W  words started (see Behaviour).
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst.
- Reset (rst=1 at a clk edge): pointers=0, level=0, in_ready=1, out_valid=0, out_char=0, out_cap=0, all counters=0, in_word=0.
  - Reset mid-stream discards buffered data. An in-flight push or pop in the reset cycle is ignored.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated at the rising edge.
- in_ready = (level != DEPTH), registered-state derived with no combinational path from out_ready.
  - Push and pop in the same cycle while full: push refused.
- out_valid = (level != 0). out_char/out_cap are driven from the head entry (first-word-fall-through).
  - A byte pushed into an empty FIFO at edge N is visible with out_valid=1 after edge N. Latency is 1 cycle.
- Simultaneous push and pop with 0 < level < DEPTH: level unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- out_char/out_cap hold their value while out_valid=1 and out_ready=0.
- Statistics update on each push only; pops do not affect them:
  - char_count += 1.
  - cap_count += 1 if in_cap=1.
  - is_letter = in_char in 0x41..0x5A or 0x61..0x7A.
  - word_count += 1 if is_letter and in_word=0.
  - in_word <= is_letter.
- All counters saturate at 2^CNT_W-1 and never wrap.
- stats_clr=1 zeroes the three counters and in_word. It has priority over a coincident push: that byte is buffered but not counted. The FIFO is unaffected.
- Non-letter bytes (digits, space, punctuation) end a word.
- Byte values ≥0x80 are stored and passed through unchanged.

Decomposition:
- Shared package `text_pkg`:
  - ASCII constants: CH_A_UP=8'h41, CH_Z_UP=8'h5A, CH_A_LO=8'h61, CH_Z_LO=8'h7A, CH_SPACE=8'h20.
  - Function `is_letter(byte)`, also used by the converter.
- Sub-module `sync_fifo` (WIDTH=9, DEPTH): storage, pointers, level, valid/ready.
- The top level holds the statistics logic and in_word flag.

Test Plan:
- Reset then idle → in_ready=1, out_valid=0, level=0, all counts 0. Push 0x41 with cap=1, out_ready=0 → next cycle out_valid=1, out_char=0x41, out_cap=1, char_count=1, cap_count=1, word_count=1.
- Push "Hi yo" (0x48,0x69,0x20,0x79,0x6F), out_ready=1 throughout → output order identical with 1-cycle latency; char_count=5, word_count=2, level returns to 0.
- out_ready=0, push 9 bytes 0x61..0x69 → in_ready drops after the 8th, 9th held upstream, level=8. Then out_ready=1 for one cycle with in_valid=1 → pop 0x61, no push; next cycle push 0x69 accepted.
- Fill to level=4, then push and pop every cycle for 12 cycles → level stays 4, data order preserved across pointer wrap.
- CNT_W=4, push 20 bytes with cap=1 → char_count=cap_count=15 (saturated). stats_clr with coincident push → counts 0, byte still emitted.
- Level=5, assert rst for one cycle with push and pop active → level=0, out_valid=0, counters 0. Next push 0x5A appears as the sole output.
